// File: rtl/pipe_stage_skid.sv
// Reusable pipeline stage register with a 2-entry skid buffer and flush.
// Define PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_stage_skid #(
    parameter int unsigned       WIDTH      = 32,
    parameter logic [WIDTH-1:0]  RESET_DATA = '0,
    parameter int unsigned       CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef PIPE_STALL_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
`endif
    input  logic             flush
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_main_valid;
    logic             w_skid_valid;
    logic             w_acc;
    logic             w_pop;

    assign w_main_valid = (r_state != S_EMPTY);
    assign w_skid_valid = (r_state == S_FULL);

    // Ready comes straight from the skid flag, never from out_ready.
    assign in_ready  = ~w_skid_valid & ~flush;
    assign out_valid = w_main_valid;
    assign out_data  = r_main_data;

    assign w_acc = in_valid & in_ready;
    assign w_pop = w_main_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main_data;
        w_skid_nxt  = r_skid_data;
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = RESET_DATA;
            w_skid_nxt  = RESET_DATA;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = in_data;
                    end
                end
                S_ONE: begin
                    if (w_acc && w_pop) begin
                        w_main_nxt = in_data;
                    end else if (w_acc) begin
                        w_state_nxt = S_FULL;
                        w_skid_nxt  = in_data;
                    end else if (w_pop) begin
                        w_state_nxt = S_EMPTY;
                        w_main_nxt  = RESET_DATA;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = r_skid_data;
                        w_skid_nxt  = RESET_DATA;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_main_nxt  = RESET_DATA;
                    w_skid_nxt  = RESET_DATA;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_EMPTY;
            r_main_data <= RESET_DATA;
            r_skid_data <= RESET_DATA;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_nxt;
            r_skid_data <= w_skid_nxt;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturates instead of wrapping; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_main_valid && !out_ready && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed steps plus random traffic
// checked against a queue-based model of the stage.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        flush;
`ifdef PIPE_STALL_CNT_EN
    logic [3:0]  stall_cnt;
`endif

    int          total = 0;
    int          bad = 0;
    logic [31:0] q[$];
    int          cnt_m = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .WIDTH(32),
        .RESET_DATA(32'h0),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
`ifdef PIPE_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .flush(flush)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive, check against the model, then advance the model.
    task automatic cyc(input logic v, input logic [31:0] d,
                       input logic ordy, input logic fl,
                       input logic rst, input bit ck);
        bit          e_ov;
        bit          e_rdy;
        logic [31:0] e_od;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #1;
        e_ov  = (q.size() > 0);
        e_od  = e_ov ? q[0] : 32'h0;
        e_rdy = (q.size() < 2) && !fl;
        if (ck) begin
            chk("out_valid", {31'h0, out_valid}, {31'h0, e_ov});
            chk("out_data", out_data, e_od);
            chk("in_ready", {31'h0, in_ready}, {31'h0, e_rdy});
`ifdef PIPE_STALL_CNT_EN
            chk("stall_cnt", {28'h0, stall_cnt}, cnt_m);
`endif
        end
        @(posedge clk);
        if (!rst) begin
            q.delete();
            cnt_m = 0;
        end else begin
            if (e_ov && !ordy && cnt_m < 15) cnt_m++;
            if (fl) begin
                q.delete();
            end else begin
                if (e_ov && ordy) void'(q.pop_front());
                if (v && e_rdy) q.push_back(d);
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = 32'h0;
        out_ready = 1'b0;
        flush = 1'b0;

        // Reset with garbage offered upstream
        cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Single transfer
        cyc(1'b1, 32'h00400000, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Streaming 1..8
        for (int i = 1; i <= 8; i++)
            cyc(1'b1, i, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Backpressure: A, B fill, C held until space frees
        cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Flush while FULL, input offered during flush is refused
        cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 32'hE, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 32'hD, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);

`ifdef PIPE_STALL_CNT_EN
        // Counter saturation, kept by flush, cleared by reset
        cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("stall_sat", {28'h0, stall_cnt}, 32'hF);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("stall_flush", {28'h0, stall_cnt}, 32'hF);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("stall_rst", {28'h0, stall_cnt}, 32'h0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom % 2), $urandom, 1'($urandom % 3 != 0),
                1'($urandom % 20 == 0), 1'($urandom % 50 != 0), 1'b1);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
